// File: rtl/seq_shift_unit_if.sv
// Request/response bundle for the iterative shifter: operand and mode in,
// shifted result out, each side with its own valid/ready pair.
interface seq_shift_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic [31:0]      shift;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, X, shift, mode, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, X, shift, mode, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/seq_shift_unit.sv
// Iterative SLL/SRL/SRA/ROR shifter: moves at most STEP bit positions per clock
// until the latched shift amount is used up, then holds the result for handshake.
//
//  state | meaning
//  IDLE  | waiting for a request, in_ready high
//  SHIFT | shifting the work register by up to STEP per edge
//  DONE  | result valid, waiting for out_ready
module seq_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input logic           clk,
  input logic           rst_n,
  seq_shift_unit_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W:0] STEP_C  = (SHAMT_W + 1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_C = (SHAMT_W + 1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   work_d;
  logic [SHAMT_W-1:0] rem_q;
  logic [SHAMT_W-1:0] rem_d;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   result_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [SHAMT_W:0]   amt;
  logic               unused_shift_hi;

  assign unused_shift_hi = ^bus.shift[31:SHAMT_W];

  // amt never exceeds rem, and rem is always below WIDTH, so the ROR
  // left-shift by WIDTH-amt is never a full-width shift.
  always_comb begin
    amt    = ({1'b0, rem_q} < STEP_C) ? {1'b0, rem_q} : STEP_C;
    work_d = work_q;
    case (mode_q)
      2'b00: work_d = work_q << amt;
      2'b01: work_d = work_q >> amt;
      2'b10: work_d = WIDTH'($signed(work_q) >>> amt);
      2'b11: work_d = (work_q >> amt) | (work_q << (WIDTH_C - amt));
      default: work_d = work_q;
    endcase
    rem_d = rem_q - amt[SHAMT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      rem_q       <= '0;
      mode_q      <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            work_q     <= bus.X;
            rem_q      <= bus.shift[SHAMT_W-1:0];
            mode_q     <= bus.mode;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.shift[SHAMT_W-1:0] == '0) begin
              result_q    <= bus.X;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            result_q    <= work_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit at WIDTH=32, STEP=4: results, latencies,
// back-pressure and asynchronous reset against hand-computed values.
module tb_seq_shift_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_shift_unit_if #(.WIDTH(32)) bus ();

  seq_shift_unit #(.WIDTH(32), .STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Drives one request (inputs scrambled right after the accept edge), waits
  // for out_valid, then completes the handshake. Returns observations only.
  task automatic do_op(input logic [31:0] x, input logic [31:0] sh, input logic [1:0] md,
                       output logic [31:0] res, output int lat,
                       output logic [31:0] res_after, output logic rdy_after);
    bus.X = x; bus.shift = sh; bus.mode = md; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.X = ~x; bus.shift = sh + 32'd5; bus.mode = ~md;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    res_after = bus.result;
    rdy_after = bus.in_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.X = '0; bus.shift = '0; bus.mode = '0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b result=%h expected 1 0 0 00000000",
               bus.in_ready, bus.out_valid, bus.busy, bus.result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    logic [31:0] vx [14] = '{32'hFFFFFFF8, 32'h80000000, 32'h80000000, 32'hA5A5A5A5,
                             32'h00000001, 32'h00000018, 32'h55555555, 32'h00000001,
                             32'h0000000F, 32'h00000100, 32'h7FFFFFFF, 32'h12345678,
                             32'h80000001, 32'hF0000000};
    logic [31:0] vs [14] = '{32'd3, 32'h1F, 32'h1F, 32'd16, 32'd2, 32'd2, 32'd1, 32'd5,
                             32'd6, 32'hFFFFFF04, 32'd31, 32'd8, 32'd4, 32'd31};
    logic [1:0]  vm [14] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00,
                             2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    logic [31:0] ve [14] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h0000A5A5,
                             32'h00000004, 32'h00000006, 32'hAAAAAAAA, 32'h00000020,
                             32'h3C000000, 32'h00000010, 32'h00000000, 32'h78123456,
                             32'h00000010, 32'h00000000};
    int          vl [14] = '{2, 9, 9, 5, 2, 2, 2, 3, 3, 2, 9, 3, 2, 9};
    logic [31:0] res, res_after;
    int          lat;
    logic        rdy;
    for (int i = 0; i < 14; i++) begin
      do_op(vx[i], vs[i], vm[i], res, lat, res_after, rdy);
      checks++;
      if (res !== ve[i]) begin
        errors++;
        $display("FAIL vec%0d result: got %h expected %h", i, res, ve[i]);
      end
      checks++;
      if (lat != vl[i]) begin
        errors++;
        $display("FAIL vec%0d latency: got %0d expected %0d", i, lat, vl[i]);
      end
      checks++;
      if (res_after !== ve[i] || rdy !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d post-handshake: result=%h in_ready=%b expected %h 1", i, res_after, rdy, ve[i]);
      end
    end
  endtask

  task automatic test_zero_wrap();
    logic [31:0] res, res_after;
    int          lat;
    logic        rdy;
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 2; k++) begin
        do_op(32'hFFFFFFFF, (k == 0) ? 32'd0 : 32'd32, 2'(m), res, lat, res_after, rdy);
        checks++;
        if (res !== 32'hFFFFFFFF || lat != 1) begin
          errors++;
          $display("FAIL zero_wrap m%0d k%0d: result=%h latency=%0d expected FFFFFFFF 1", m, k, res, lat);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.X = 32'h000000F0; bus.shift = 32'd4; bus.mode = 2'b01; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.X = 32'h00000001; bus.shift = 32'd1; bus.mode = 2'b00;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 2 || bus.result !== 32'h0000000F) begin
      errors++;
      $display("FAIL bp_first: result=%h latency=%0d expected 0000000F 2", bus.result, lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.result !== 32'h0000000F || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: result=%h out_valid=%b in_ready=%b expected 0000000F 1 0",
                 c, bus.result, bus.out_valid, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_handshake: out_valid=%b in_ready=%b busy=%b expected 0 1 0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept: busy=%b in_ready=%b expected 1 0", bus.busy, bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h00000002) begin
      errors++;
      $display("FAIL bp_second_result: out_valid=%b result=%h expected 1 00000002", bus.out_valid, bus.result);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res, res_after;
    int          lat;
    logic        rdy;
    bus.X = 32'hFFFFFFFF; bus.shift = 32'd31; bus.mode = 2'b01; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy: busy=%b out_valid=%b expected 1 0", bus.busy, bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b result=%h in_ready=%b busy=%b expected 0 00000000 1 0",
               bus.out_valid, bus.result, bus.in_ready, bus.busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'h80000000, 32'd4, 2'b10, res, lat, res_after, rdy);
    checks++;
    if (res !== 32'hF8000000 || lat != 2) begin
      errors++;
      $display("FAIL mid_recover: result=%h latency=%0d expected F8000000 2", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_zero_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
